// File: rtl/mux_arb_reg.sv
// N-channel registered multiplexer with valid/ready handshakes on every input and the output.
// Selects by direct index (mode=0) or round-robin among valid channels (mode=1).
module mux_arb_reg #(
    parameter int WIDTH = 32,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    input  logic [SELW-1:0]      sel,
    input  logic                 mode,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [NCH-1:0]       grant,
    output logic                 err
);

    localparam logic [SELW-1:0] RR_RESET = SELW'(NCH - 1);

    logic [WIDTH-1:0] w_ch_data [NCH];
    logic [NCH-1:0]   w_cand_onehot;
    logic [SELW-1:0]  w_cand_idx;
    logic             w_cand_found;
    logic [WIDTH-1:0] w_cand_data;
    logic             w_can_load;
    logic             w_xfer;
    logic             w_sel_oob;

    logic [SELW-1:0]  r_rr_ptr;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [NCH-1:0]   r_grant;
    logic             r_err;

    assign w_can_load = !r_out_valid || out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_ch
            assign w_ch_data[gi]     = in_data[gi*WIDTH +: WIDTH];
            assign w_cand_onehot[gi] = w_cand_found && (w_cand_idx == SELW'(gi));
            assign in_ready[gi]      = w_cand_onehot[gi] && w_can_load;
        end

        // With a fully populated select space no index can be out of range.
        if (NCH < (1 << SELW)) begin : g_oob
            assign w_sel_oob = !mode && (sel > SELW'(NCH - 1));
        end else begin : g_no_oob
            assign w_sel_oob = 1'b0;
        end
    endgenerate

    // Candidate selection. Round-robin runs two descending passes so the lowest valid
    // channel above rr_ptr wins, falling back to the lowest valid channel at or below it.
    always_comb begin
        w_cand_found = 1'b0;
        w_cand_idx   = '0;
        if (!mode) begin
            for (int i = 0; i < NCH; i++) begin
                if (sel == SELW'(i) && in_valid[i]) begin
                    w_cand_found = 1'b1;
                    w_cand_idx   = SELW'(i);
                end
            end
        end else begin
            for (int i = NCH - 1; i >= 0; i--) begin
                if (in_valid[i] && (SELW'(i) <= r_rr_ptr)) begin
                    w_cand_found = 1'b1;
                    w_cand_idx   = SELW'(i);
                end
            end
            for (int i = NCH - 1; i >= 0; i--) begin
                if (in_valid[i] && (SELW'(i) > r_rr_ptr)) begin
                    w_cand_found = 1'b1;
                    w_cand_idx   = SELW'(i);
                end
            end
        end
    end

    always_comb begin
        w_cand_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_cand_onehot[i]) begin
                w_cand_data = w_ch_data[i];
            end
        end
    end

    assign w_xfer = w_cand_found && w_can_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_grant     <= '0;
            r_err       <= 1'b0;
            r_rr_ptr    <= RR_RESET;
        end else begin
            r_err <= w_sel_oob;
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_cand_data;
                r_grant     <= w_cand_onehot;
                r_rr_ptr    <= w_cand_idx;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign grant     = r_grant;
    assign err       = r_err;

endmodule
